gcm_pkt_arbiter: RTL and testbench

GCM_PKT_ARBITER -- requirements
Module: gcm_pkt_arbiter

---
 rtl/gcm_pkt_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_gcm_pkt_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_pkt_arbiter.sv
// Two-port packet arbiter feeding a GCM datapath: packet-locked round-robin
// grant, one-cycle issue register, and a tag FIFO that routes results back in order.
module gcm_pkt_arbiter #(
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_valid0,
  input  logic                         i_valid1,
  output logic                         o_ready0,
  output logic                         o_ready1,
  input  logic                         i_last0,
  input  logic                         i_last1,
  input  logic [0:127]                 i_data0,
  input  logic [0:127]                 i_data1,
  input  logic [288:0]                 i_bypass0,
  input  logic [288:0]                 i_bypass1,
  output logic                         o_new,
  output logic                         o_last,
  output logic [0:127]                 o_plain_text,
  output logic [288:0]                 o_bypass_text,
  input  logic                         i_cp_ready,
  input  logic [0:127]                 i_cipher_text,
  output logic                         o_res_valid0,
  output logic                         o_res_valid1,
  output logic                         o_res_last,
  output logic [0:127]                 o_res_text,
  output logic [$clog2(TAG_DEPTH):0]   o_outstanding,
  output logic                         o_err_underflow
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(TAG_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          rr_reg, rr_next;

  logic [1:0]    valid;
  logic [1:0]    last;
  logic [1:0]    ready;
  logic [1:0]    xfer;

  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    tag_mem [TAG_DEPTH];
  logic [1:0]    head_tag;
  logic          tag_full, fifo_empty;
  logic          push, pop, push_port, push_last;

  assign valid = {i_valid1, i_valid0};
  assign last  = {i_last1, i_last0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign xfer[gi] = valid[gi] & ready[gi];
    end
  endgenerate

  assign o_ready0 = ready[0];
  assign o_ready1 = ready[1];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (valid == 2'b11)
          state_next = rr_reg ? GRANT1 : GRANT0;
        else if (valid[0])
          state_next = GRANT0;
        else if (valid[1])
          state_next = GRANT1;
      end
      GRANT0: begin
        if (xfer[0] && last[0]) begin
          state_next = IDLE;
          rr_next    = 1'b1;
        end
      end
      GRANT1: begin
        if (xfer[1] && last[1]) begin
          state_next = IDLE;
          rr_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Ready looks only at the registered count, so a same-cycle pop cannot unblock it.
  always_comb begin
    ready = 2'b00;
    if (!tag_full) begin
      case (state_reg)
        GRANT0:  ready[0] = 1'b1;
        GRANT1:  ready[1] = 1'b1;
        default: ready    = 2'b00;
      endcase
    end
  end

  // ---------------- tag FIFO ----------------
  assign fifo_empty = (count_reg == '0);
  assign tag_full   = (count_reg == FULL_COUNT);
  assign push       = |xfer;
  assign push_port  = xfer[1];
  assign push_last  = xfer[1] ? i_last1 : i_last0;
  assign pop        = i_cp_ready & ~fifo_empty;
  assign head_tag   = tag_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr_reg] <= {push_port, push_last};
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  assign o_outstanding = count_reg;

  // ---------------- issue register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_new         <= 1'b0;
      o_last        <= 1'b0;
      o_plain_text  <= '0;
      o_bypass_text <= '0;
    end else begin
      o_new <= push;
      if (push) begin
        o_last        <= push_last;
        o_plain_text  <= xfer[1] ? i_data1 : i_data0;
        o_bypass_text <= xfer[1] ? i_bypass1 : i_bypass0;
      end
    end
  end

  // ---------------- result routing ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_res_valid0    <= 1'b0;
      o_res_valid1    <= 1'b0;
      o_res_last      <= 1'b0;
      o_res_text      <= '0;
      o_err_underflow <= 1'b0;
    end else begin
      o_res_valid0 <= pop & ~head_tag[1];
      o_res_valid1 <= pop & head_tag[1];
      if (pop) begin
        o_res_last <= head_tag[0];
        o_res_text <= i_cipher_text;
      end
      if (i_cp_ready && fifo_empty)
        o_err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcm_pkt_arbiter.sv
// Bench for gcm_pkt_arbiter: directed scenarios plus a randomized run checked
// against a packet-level model (owner/preference plus a queue of tags).
module tb_gcm_pkt_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0, cp = 1'b0;
  logic [0:127]   d0 = '0, d1 = '0, ct = '0;
  logic [288:0]   b0 = '0, b1 = '0;
  logic           o_ready0, o_ready1, o_new, o_last;
  logic [0:127]   o_plain_text, o_res_text;
  logic [288:0]   o_bypass_text;
  logic           o_res_valid0, o_res_valid1, o_res_last, o_err_underflow;
  logic [AW:0]    o_outstanding;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcm_pkt_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid0(v0), .i_valid1(v1), .o_ready0(o_ready0), .o_ready1(o_ready1),
    .i_last0(l0), .i_last1(l1), .i_data0(d0), .i_data1(d1),
    .i_bypass0(b0), .i_bypass1(b1),
    .o_new(o_new), .o_last(o_last), .o_plain_text(o_plain_text), .o_bypass_text(o_bypass_text),
    .i_cp_ready(cp), .i_cipher_text(ct),
    .o_res_valid0(o_res_valid0), .o_res_valid1(o_res_valid1), .o_res_last(o_res_last),
    .o_res_text(o_res_text), .o_outstanding(o_outstanding), .o_err_underflow(o_err_underflow)
  );

  // ---------------- reference model ----------------
  int           owner, pref;            // owner -1 means nobody holds the grant
  logic [1:0]   tagq[$];                // {port, last}
  logic         exp_ready0, exp_ready1, exp_new, exp_last;
  logic         exp_rv0, exp_rv1, exp_res_last, exp_err;
  logic [0:127] exp_plain, exp_res_text;
  logic [288:0] exp_bypass;
  logic         acc0, acc1;

  task automatic model_reset();
    owner = -1; pref = 0; tagq.delete();
    exp_ready0 = 0; exp_ready1 = 0; exp_new = 0; exp_last = 0;
    exp_rv0 = 0; exp_rv1 = 0; exp_res_last = 0; exp_err = 0;
    exp_plain = '0; exp_res_text = '0; exp_bypass = '0; acc0 = 0; acc1 = 0;
  endtask

  // Applies the current inputs across one rising edge and updates the model.
  task automatic step();
    logic x0, x1;
    logic [1:0] head;
    x0 = v0 && exp_ready0;
    x1 = v1 && exp_ready1;
    exp_new = x0 | x1;
    if (x0) begin exp_last = l0; exp_plain = d0; exp_bypass = b0; end
    else if (x1) begin exp_last = l1; exp_plain = d1; exp_bypass = b1; end
    exp_rv0 = 0; exp_rv1 = 0;
    if (cp) begin
      if (tagq.size() > 0) begin
        head = tagq.pop_front();
        exp_rv0 = ~head[1]; exp_rv1 = head[1];
        exp_res_last = head[0]; exp_res_text = ct;
      end else exp_err = 1;
    end
    if (x0) tagq.push_back({1'b0, l0});
    if (x1) tagq.push_back({1'b1, l1});
    if (owner < 0) begin
      if (v0 && !v1) owner = 0;
      else if (v1 && !v0) owner = 1;
      else if (v0 && v1) owner = pref;
    end else if ((x0 && l0) || (x1 && l1)) begin
      pref = 1 - owner; owner = -1;
    end
    acc0 = x0; acc1 = x1;
    @(posedge clk);
    @(negedge clk);
    exp_ready0 = (owner == 0) && (tagq.size() < DEPTH);
    exp_ready1 = (owner == 1) && (tagq.size() < DEPTH);
  endtask

  task automatic drive_idle();
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; cp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [288:0] rand289();
    logic [319:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[288:0];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({o_new, o_last, o_ready0, o_ready1, o_res_valid0, o_res_valid1, o_res_last, o_err_underflow} !== 8'h00) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000000",
        {o_new, o_last, o_ready0, o_ready1, o_res_valid0, o_res_valid1, o_res_last, o_err_underflow});
    end
    @(negedge clk);
    checks++;
    if (o_outstanding !== '0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", o_outstanding); end
    checks++;
    if (o_plain_text !== '0 || o_bypass_text !== '0 || o_res_text !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", o_plain_text, o_bypass_text, o_res_text);
    end
    reset_n = 1;
    model_reset();
    step();
    checks++;
    if ({o_ready0, o_ready1, o_new} !== 3'b000) begin
      failures++; $display("FAIL reset_idle got=%b exp=000", {o_ready0, o_ready1, o_new});
    end
  endtask

  task automatic test_single_packet();
    logic [0:127] w[3];
    logic [0:127] c[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin w[i] = rand128(); c[i] = rand128(); end
    v0 = 1; l0 = 0; d0 = w[0];
    step();
    checks++;
    if ({o_new, o_ready0, o_ready1} !== 3'b010) begin
      failures++; $display("FAIL single_grant got=%b exp=010", {o_new, o_ready0, o_ready1});
    end
    for (int i = 0; i < 3; i++) begin
      d0 = w[i]; l0 = (i == 2); b0 = rand289();
      step();
      checks++;
      if (o_new !== 1'b1 || o_plain_text !== w[i] || o_last !== (i == 2)) begin
        failures++; $display("FAIL single_issue%0d got new=%b last=%b data=%h exp new=1 last=%b data=%h",
          i, o_new, o_last, o_plain_text, i == 2, w[i]);
      end
      checks++;
      if (o_outstanding !== (AW+1)'(i + 1)) begin
        failures++; $display("FAIL single_count%0d got=%0d exp=%0d", i, o_outstanding, i + 1);
      end
    end
    v0 = 0; l0 = 0;
    checks++;
    if (o_ready0 !== 1'b0) begin failures++; $display("FAIL single_bubble got=%b exp=0", o_ready0); end
    for (int i = 0; i < 3; i++) begin
      cp = 1; ct = c[i];
      step();
      checks++;
      if (o_res_valid0 !== 1'b1 || o_res_valid1 !== 1'b0 || o_res_last !== (i == 2) || o_res_text !== c[i]) begin
        failures++; $display("FAIL single_result%0d got v0=%b v1=%b last=%b text=%h exp v0=1 v1=0 last=%b text=%h",
          i, o_res_valid0, o_res_valid1, o_res_last, o_res_text, i == 2, c[i]);
      end
      checks++;
      if (o_outstanding !== (AW+1)'(2 - i)) begin
        failures++; $display("FAIL single_drain%0d got=%0d exp=%0d", i, o_outstanding, 2 - i);
      end
    end
    cp = 0;
  endtask

  task automatic test_round_robin();
    int cnt[2];
    int pat[9] = '{-1, 0, 0, -1, 1, 1, -1, 0, 0};
    logic a0, a1;
    do_reset();
    cnt[0] = 0; cnt[1] = 0;
    v0 = 1; v1 = 1;
    for (int c = 0; c < 9; c++) begin
      l0 = (cnt[0] % 2) == 1; d0 = {8'd0, 120'(cnt[0])};
      l1 = (cnt[1] % 2) == 1; d1 = {8'd1, 120'(cnt[1])};
      a0 = o_ready0; a1 = o_ready1;
      checks++;
      if (a0 && a1) begin failures++; $display("FAIL rr_both_ready cycle=%0d got=11 exp=one-hot", c); end
      step();
      if (a0) cnt[0]++;
      if (a1) cnt[1]++;
      checks++;
      if (o_new !== (pat[c] >= 0)) begin
        failures++; $display("FAIL rr_new cycle=%0d got=%b exp=%b", c, o_new, pat[c] >= 0);
      end else if (pat[c] >= 0) begin
        checks++;
        if (o_plain_text[0:7] !== 8'(pat[c]) || o_last !== ((c % 3) == 2)) begin
          failures++; $display("FAIL rr_order cycle=%0d got port=%0d last=%b exp port=%0d last=%b",
            c, o_plain_text[0:7], o_last, pat[c], (c % 3) == 2);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_full();
    logic [0:127] w17;
    do_reset();
    v0 = 1; l0 = 0;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      d0 = rand128(); b0 = rand289();
      step();
    end
    checks++;
    if (o_outstanding !== (AW+1)'(DEPTH) || o_ready0 !== 1'b0) begin
      failures++; $display("FAIL full_block got count=%0d ready=%b exp count=%0d ready=0", o_outstanding, o_ready0, DEPTH);
    end
    w17 = rand128(); d0 = w17;
    cp = 1; ct = rand128();
    step();
    cp = 0;
    checks++;
    if (o_new !== 1'b0 || o_ready0 !== 1'b1 || o_res_valid0 !== 1'b1 || o_outstanding !== (AW+1)'(DEPTH - 1)) begin
      failures++; $display("FAIL full_pop got new=%b ready=%b rv0=%b count=%0d exp new=0 ready=1 rv0=1 count=%0d",
        o_new, o_ready0, o_res_valid0, o_outstanding, DEPTH - 1);
    end
    step();
    checks++;
    if (o_new !== 1'b1 || o_plain_text !== w17 || o_outstanding !== (AW+1)'(DEPTH)) begin
      failures++; $display("FAIL full_17th got new=%b data=%h count=%0d exp new=1 data=%h count=%0d",
        o_new, o_plain_text, o_outstanding, w17, DEPTH);
    end
    v0 = 0; cp = 1;
    for (int i = 0; i < DEPTH; i++) step();
    cp = 0;
    checks++;
    if (o_outstanding !== '0 || o_err_underflow !== 1'b0) begin
      failures++; $display("FAIL full_drain got count=%0d err=%b exp count=0 err=0", o_outstanding, o_err_underflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cp = 1; ct = rand128();
    step();
    cp = 0;
    checks++;
    if ({o_res_valid0, o_res_valid1, o_err_underflow} !== 3'b001 || o_outstanding !== '0) begin
      failures++; $display("FAIL underflow got rv=%b%b err=%b count=%0d exp rv=00 err=1 count=0",
        o_res_valid0, o_res_valid1, o_err_underflow, o_outstanding);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (o_err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", o_err_underflow); end
    reset_n = 0;
    #1;
    checks++;
    if (o_err_underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear got=%b exp=0", o_err_underflow); end
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    v1 = 1; l1 = 0;
    step();
    d1 = rand128(); step();
    d1 = rand128(); step();
    checks++;
    if (o_outstanding !== (AW+1)'(2) || o_ready1 !== 1'b1) begin
      failures++; $display("FAIL midreset_setup got count=%0d ready1=%b exp count=2 ready1=1", o_outstanding, o_ready1);
    end
    v0 = 1;
    #2 reset_n = 0;
    #1;
    checks++;
    if ({o_new, o_last, o_ready0, o_ready1, o_res_valid0, o_res_valid1, o_res_last, o_err_underflow} !== 8'h00
        || o_outstanding !== '0 || o_plain_text !== '0 || o_bypass_text !== '0) begin
      failures++; $display("FAIL midreset_async got flags=%b count=%0d exp flags=00000000 count=0",
        {o_new, o_last, o_ready0, o_ready1, o_res_valid0, o_res_valid1, o_res_last, o_err_underflow}, o_outstanding);
    end
    @(negedge clk);
    reset_n = 1;
    model_reset();
    step();
    checks++;
    if (o_ready0 !== 1'b1 || o_ready1 !== 1'b0) begin
      failures++; $display("FAIL midreset_regrant got r0=%b r1=%b exp r0=1 r1=0", o_ready0, o_ready1);
    end
    drive_idle();
  endtask

  task automatic test_random();
    int left[2];
    logic [0:127] wd[2];
    logic [288:0] wb[2];
    int cp_pct;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      left[p] = $urandom_range(1, 5); wd[p] = rand128(); wb[p] = rand289();
    end
    for (int n = 0; n < 2400; n++) begin
      cp_pct = (n % 600 < 300) ? 25 : 65;
      v0 = $urandom_range(0, 99) < 75; v1 = $urandom_range(0, 99) < 75;
      d0 = wd[0]; b0 = wb[0]; l0 = (left[0] == 1);
      d1 = wd[1]; b1 = wb[1]; l1 = (left[1] == 1);
      cp = $urandom_range(0, 99) < cp_pct; ct = rand128();
      step();
      if (acc0) begin
        left[0]--; if (left[0] == 0) left[0] = $urandom_range(1, 5);
        wd[0] = rand128(); wb[0] = rand289();
      end
      if (acc1) begin
        left[1]--; if (left[1] == 0) left[1] = $urandom_range(1, 5);
        wd[1] = rand128(); wb[1] = rand289();
      end
      checks++;
      if (o_new !== exp_new || o_plain_text !== exp_plain || o_bypass_text !== exp_bypass
          || (exp_new && o_last !== exp_last)) begin
        failures++; $display("FAIL rand_issue n=%0d got new=%b last=%b data=%h exp new=%b last=%b data=%h",
          n, o_new, o_last, o_plain_text, exp_new, exp_last, exp_plain);
      end
      checks++;
      if (o_res_valid0 !== exp_rv0 || o_res_valid1 !== exp_rv1
          || ((exp_rv0 || exp_rv1) && (o_res_last !== exp_res_last || o_res_text !== exp_res_text))) begin
        failures++; $display("FAIL rand_result n=%0d got rv=%b%b last=%b text=%h exp rv=%b%b last=%b text=%h",
          n, o_res_valid0, o_res_valid1, o_res_last, o_res_text, exp_rv0, exp_rv1, exp_res_last, exp_res_text);
      end
      checks++;
      if (o_ready0 !== exp_ready0 || o_ready1 !== exp_ready1 || o_err_underflow !== exp_err
          || o_outstanding !== (AW+1)'(tagq.size())) begin
        failures++; $display("FAIL rand_status n=%0d got r=%b%b err=%b count=%0d exp r=%b%b err=%b count=%0d",
          n, o_ready0, o_ready1, o_err_underflow, o_outstanding, exp_ready0, exp_ready1, exp_err, tagq.size());
      end
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full();
    test_underflow();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
